muldiv_seq: RTL and testbench

- Iterative multiply/divide sequencer that sits beside the EX-stage ALU.
- Executes MULT/MULTU/DIV/DIVU over WIDTH+1 cycles, owns the HI/LO registers and handles MTHI/MTLO.
- Raises a stall request so decode/EX hold while it is busy.
- Shift-add multiply and restoring divide on operand magnitudes, with sign fix-up in a final cycle.

---
 rtl/muldiv_seq_if.sv | 27 ++
 rtl/muldiv_seq.sv | 175 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// Pipeline-side bundle for the iterative multiply/divide sequencer.
// The EX stage drives the request side (master); the sequencer answers with
// its status and the architectural HI/LO values (slave).
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             flush;
    logic             busy;
    logic             stall_req;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, A, B, flush,
        input  busy, stall_req, done, hi, lo
    );

    modport slave (
        input  start, op, A, B, flush,
        output busy, stall_req, done, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// Operands are reduced to magnitudes on acceptance, WIDTH shift-add or
// restoring-divide iterations follow, and a final FIX cycle applies the sign
// correction and writes HI/LO. MTHI/MTLO complete in the accept cycle.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_seq_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_neg_q;      // product / quotient needs negation
    logic               r_neg_r;      // remainder needs negation
    logic [WIDTH-1:0]   r_a;          // multiplier -> product low / dividend -> quotient
    logic [WIDTH-1:0]   r_b;          // multiplicand / divisor magnitude
    logic [WIDTH:0]     r_acc;        // product high part / partial remainder
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    // Request decode
    logic               w_idle;
    logic               w_accept;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_div0;

    // Iteration datapath
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH+1:0]   w_div_diff;
    logic               w_div_ok;

    // Fix-up datapath
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = w_idle && bus.start && !bus.flush && (bus.op <= 3'd3);
    // MULT (0) and DIV (2) are the signed forms
    assign w_signed = !bus.op[0];
    assign w_a_neg  = w_signed && bus.A[WIDTH-1];
    assign w_b_neg  = w_signed && bus.B[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -bus.A : bus.A;
    assign w_b_mag  = w_b_neg ? -bus.B : bus.B;
    // A zero divisor runs the raw dividend unsigned through the divider: the
    // quotient saturates to all ones and the remainder ends up equal to A.
    assign w_div0   = bus.op[1] && (bus.B == '0);

    // Shift-add step: add multiplicand when the current multiplier LSB is set
    assign w_mul_sum   = r_acc + (r_a[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    // Restoring step: bring in the next dividend bit and trial-subtract
    assign w_div_shift = {r_acc[WIDTH-1:0], r_a[WIDTH-1]};
    assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_b};
    assign w_div_ok    = !w_div_diff[WIDTH+1];

    assign w_prod     = {r_acc[WIDTH-1:0], r_a};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo_fix  = r_neg_q ? -r_a : r_a;
    assign w_rem_fix  = r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; flush returns to IDLE from any state
    always_comb begin
        w_state_next = r_state;
        if (bus.flush) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) w_state_next = ST_RUN;
                ST_RUN:  if (r_cnt == CW'(WIDTH - 1)) w_state_next = ST_FIX;
                ST_FIX:  w_state_next = ST_IDLE;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Operand latch, iteration datapath and iteration counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_is_div <= bus.op[1];
            r_acc    <= '0;
            r_b      <= w_b_mag;
            if (w_div0) begin
                r_a     <= bus.A;
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
            end else begin
                r_a     <= w_a_mag;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= bus.op[1] && w_a_neg;
            end
        end else if ((r_state == ST_RUN) && !bus.flush) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_is_div) begin
                r_acc <= w_div_ok ? w_div_diff[WIDTH:0] : w_div_shift;
                r_a   <= {r_a[WIDTH-2:0], w_div_ok};
            end else begin
                r_acc <= {1'b0, w_mul_sum[WIDTH:1]};
                r_a   <= {w_mul_sum[0], r_a[WIDTH-1:1]};
            end
        end
    end

    // HI/LO: written by MTHI/MTLO in IDLE or by the FIX cycle of a mul/div
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (!bus.flush) begin
            if (w_idle && bus.start && (bus.op == 3'd4)) begin
                r_hi <= bus.A;
            end else if (w_idle && bus.start && (bus.op == 3'd5)) begin
                r_lo <= bus.A;
            end else if (r_state == ST_FIX) begin
                if (r_is_div) begin
                    r_hi <= w_rem_fix;
                    r_lo <= w_quo_fix;
                end else begin
                    r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod_fix[WIDTH-1:0];
                end
            end
        end
    end

    // Completion pulse in the cycle after HI/LO are written by a mul/div
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == ST_FIX) && !bus.flush;
        end
    end

    assign bus.busy      = !w_idle;
    assign bus.stall_req = bus.busy || w_accept;
    assign bus.done      = r_done;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: arithmetic results, latency, MTHI/MTLO,
// busy-start rejection, flush and asynchronous reset.
module tb_muldiv_seq;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    muldiv_seq_if #(.WIDTH(32)) bus_if ();

    muldiv_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one mul/div, measure busy length, check done pulse and HI/LO.
    // With inject set, a MULTU is presented mid-run and must be ignored.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input bit inject);
        int n;
        bus_if.start = 1'b1;
        bus_if.op    = op;
        bus_if.A     = a;
        bus_if.B     = b;
        #1;
        check_val({tag, "_stall_accept"}, 64'(bus_if.stall_req), 64'd1);
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        bus_if.A     = ~a;
        bus_if.B     = ~b;
        n = 0;
        while (bus_if.busy && n < 100) begin
            n++;
            check_val({tag, "_stall_busy"}, 64'(bus_if.stall_req), 64'd1);
            check_val({tag, "_done_busy"}, 64'(bus_if.done), 64'd0);
            if (inject && n == 5) begin
                bus_if.start = 1'b1;
                bus_if.op    = 3'd1;
                bus_if.A     = 32'd5;
                bus_if.B     = 32'd5;
            end else begin
                bus_if.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus_if.start = 1'b0;
        check_val({tag, "_latency"}, 64'(n), 64'd33);
        check_val({tag, "_done"}, 64'(bus_if.done), 64'd1);
        check_val({tag, "_hi"}, 64'(bus_if.hi), 64'(exp_hi));
        check_val({tag, "_lo"}, 64'(bus_if.lo), 64'(exp_lo));
        $display("txn %s op=%0d A=%h B=%h -> hi=%h lo=%h cycles=%0d",
                 tag, op, a, b, bus_if.hi, bus_if.lo, n);
        @(posedge clk); #1;
        check_val({tag, "_done_clear"}, 64'(bus_if.done), 64'd0);
        check_val({tag, "_idle_after"}, 64'(bus_if.busy), 64'd0);
    endtask

    task automatic write_hilo(input logic [2:0] op, input logic [31:0] a);
        bus_if.start = 1'b1;
        bus_if.op    = op;
        bus_if.A     = a;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
    endtask

    initial begin
        int done_seen;
        n_checks = 0;
        n_errors = 0;
        rst           = 1'b1;
        bus_if.start  = 1'b0;
        bus_if.op     = 3'd7;
        bus_if.A      = '0;
        bus_if.B      = '0;
        bus_if.flush  = 1'b0;
        #1;
        check_val("rst_busy", 64'(bus_if.busy), 64'd0);
        check_val("rst_done", 64'(bus_if.done), 64'd0);
        check_val("rst_hi", 64'(bus_if.hi), 64'd0);
        check_val("rst_lo", 64'(bus_if.lo), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op("mult_neg",  3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        run_op("mult_min",  3'd0, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000, 1'b0);
        run_op("div_neg",   3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("div_negb",  3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        run_op("divu",      3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_op("divu_zero", 3'd3, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF, 1'b0);
        run_op("div_zero",  3'd2, 32'hFFFFFFF0, 32'h0, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b0);
        run_op("div_ovf",   3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        run_op("busy_ign",  3'd1, 32'd6, 32'd9, 32'd0, 32'd54, 1'b1);

        // MTHI then MTLO on consecutive cycles
        bus_if.start = 1'b1;
        bus_if.op    = 3'd4;
        bus_if.A     = 32'hDEADBEEF;
        #1;
        check_val("mthi_stall", 64'(bus_if.stall_req), 64'd0);
        @(posedge clk); #1;
        check_val("mthi_hi", 64'(bus_if.hi), 64'hDEADBEEF);
        check_val("mthi_busy", 64'(bus_if.busy), 64'd0);
        bus_if.op = 3'd5;
        bus_if.A  = 32'h0BADF00D;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        check_val("mtlo_lo", 64'(bus_if.lo), 64'h0BADF00D);
        check_val("mtlo_hi_keep", 64'(bus_if.hi), 64'hDEADBEEF);
        check_val("mtlo_busy", 64'(bus_if.busy), 64'd0);
        check_val("mtlo_done", 64'(bus_if.done), 64'd0);
        $display("txn mthi/mtlo -> hi=%h lo=%h", bus_if.hi, bus_if.lo);

        // Flush in RUN
        write_hilo(3'd4, 32'hAAAA0000);
        write_hilo(3'd5, 32'h00005555);
        bus_if.start = 1'b1;
        bus_if.op    = 3'd0;
        bus_if.A     = 32'd3;
        bus_if.B     = 32'd5;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check_val("flush_pre_busy", 64'(bus_if.busy), 64'd1);
        bus_if.flush = 1'b1;
        @(posedge clk); #1;
        bus_if.flush = 1'b0;
        check_val("flush_busy", 64'(bus_if.busy), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus_if.done || bus_if.busy) done_seen++;
        end
        check_val("flush_no_done", 64'(done_seen), 64'd0);
        check_val("flush_hi", 64'(bus_if.hi), 64'hAAAA0000);
        check_val("flush_lo", 64'(bus_if.lo), 64'h00005555);
        $display("txn flush in RUN -> hi=%h lo=%h", bus_if.hi, bus_if.lo);

        // Flush in IDLE suppresses MTHI and mul/div acceptance
        bus_if.flush = 1'b1;
        bus_if.start = 1'b1;
        bus_if.op    = 3'd4;
        bus_if.A     = 32'h11111111;
        @(posedge clk); #1;
        check_val("flush_mthi", 64'(bus_if.hi), 64'hAAAA0000);
        bus_if.op = 3'd0;
        #1;
        check_val("flush_stall", 64'(bus_if.stall_req), 64'd0);
        @(posedge clk); #1;
        check_val("flush_start_busy", 64'(bus_if.busy), 64'd0);
        bus_if.start = 1'b0;
        bus_if.flush = 1'b0;
        $display("txn flush in IDLE -> hi=%h busy=%0d", bus_if.hi, bus_if.busy);

        // Asynchronous reset mid-divide
        bus_if.start = 1'b1;
        bus_if.op    = 3'd2;
        bus_if.A     = 32'd100;
        bus_if.B     = 32'd7;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check_val("arst_pre_busy", 64'(bus_if.busy), 64'd1);
        rst = 1'b1;
        #1;
        check_val("arst_busy", 64'(bus_if.busy), 64'd0);
        check_val("arst_stall", 64'(bus_if.stall_req), 64'd0);
        check_val("arst_done", 64'(bus_if.done), 64'd0);
        check_val("arst_hi", 64'(bus_if.hi), 64'd0);
        check_val("arst_lo", 64'(bus_if.lo), 64'd0);
        $display("txn reset mid-DIV -> hi=%h lo=%h busy=%0d", bus_if.hi, bus_if.lo, bus_if.busy);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
